dense_layer_mac: RTL and testbench

//  Fully-connected layer accumulator directly upstream of the activation stage.

---
 rtl/dense_layer_mac_if.sv | 37 +++
 rtl/dense_layer_mac.sv | 117 +++++++++++
 tb/tb_dense_layer_mac.sv | 393 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dense_layer_mac_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : dense_layer_mac_if
//  Description : Handshake and data bundle between a dense-layer producer and
//                the dense_layer_mac accumulator block.
//                Carries bias load, the feature/weight beat stream and the
//                result vector.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dense_layer_mac_if #(
  parameter int N_OUT = 10
) ();
  logic               start;
  logic signed [31:0] bias  [N_OUT];
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] x_in;
  logic signed [31:0] w_in  [N_OUT];
  logic signed [31:0] out   [N_OUT];
  logic               out_valid;
  logic               out_ready;
  logic               busy;

  // Producer / consumer side
  modport master (
    output start, bias, in_valid, x_in, w_in, out_ready,
    input  in_ready, out, out_valid, busy
  );

  // Accumulator side
  modport slave (
    input  start, bias, in_valid, x_in, w_in, out_ready,
    output in_ready, out, out_valid, busy
  );
endinterface
`default_nettype wire

// File: rtl/dense_layer_mac.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : dense_layer_mac
//  Description : Fully-connected layer accumulator. Loads per-neuron biases on
//                start, streams N_IN feature beats (x, w[N_OUT]) and sums
//                bias + sum(x*w) into N_OUT signed 32-bit accumulators, then
//                presents the vector under a valid/ready handshake.
//                Arithmetic wraps in two's complement (low 32 bits kept).
//  Revision    : 1.0 - initial release
// ============================================================================
module dense_layer_mac #(
  parameter int N_IN  = 16,
  parameter int N_OUT = 10
) (
  input  logic             clk,
  input  logic             rst,
  dense_layer_mac_if.slave bus
);

  localparam int                 c_cnt_w = $clog2(N_IN) + 1;
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(N_IN - 1);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t              r_state;
  logic signed [31:0]  r_acc [N_OUT];
  logic [c_cnt_w-1:0]  r_cnt;
  logic                r_in_ready;
  logic                r_out_valid;
  logic                r_busy;

  logic signed [31:0]  w_prod [N_OUT];

  // Per-neuron product (32-bit context keeps the low word) and result fan-out
  generate
    for (genvar j = 0; j < N_OUT; j++) begin : g_lane
      assign w_prod[j]  = bus.x_in * bus.w_in[j];
      assign bus.out[j] = r_acc[j];
    end
  endgenerate

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;

  // Control FSM with accumulator datapath; flags are registered alongside the
  // state so they always match the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      for (int j = 0; j < N_OUT; j++) r_acc[j] <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            for (int j = 0; j < N_OUT; j++) r_acc[j] <= bus.bias[j];
            r_cnt      <= '0;
            r_state    <= ST_ACCUM;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end

        ST_ACCUM: begin
          // in_ready is high throughout ACCUM, so in_valid alone accepts a beat
          if (bus.in_valid) begin
            for (int j = 0; j < N_OUT; j++) r_acc[j] <= r_acc[j] + w_prod[j];
            if (r_cnt == c_last) begin
              r_cnt       <= '0;
              r_state     <= ST_HOLD;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_cnt <= r_cnt + c_one;
            end
          end
        end

        ST_HOLD: begin
          // Result is frozen until the consumer takes it; start only counts
          // together with the handshake so a new vector chains back-to-back.
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            if (bus.start) begin
              for (int j = 0; j < N_OUT; j++) r_acc[j] <= bus.bias[j];
              r_cnt      <= '0;
              r_state    <= ST_ACCUM;
              r_in_ready <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dense_layer_mac.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_dense_layer_mac
//  Description : Self-checking bench for dense_layer_mac. One instance with
//                N_IN=4 for the main scenarios, one with N_IN=1 for the
//                single-beat case. Expected vectors come from a plain
//                bias + sum(x*w) model using 32-bit int arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dense_layer_mac;

  localparam int NO = 10;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  dense_layer_mac_if #(.N_OUT(NO)) bus4 ();
  dense_layer_mac_if #(.N_OUT(NO)) bus1 ();

  dense_layer_mac #(.N_IN(4), .N_OUT(NO)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  dense_layer_mac #(.N_IN(1), .N_OUT(NO)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Absolute time bound on the whole run
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: bias + sum of x*w over nb beats, wrapping in 32 bits
  task automatic ref_model(input int b[NO], input int xs[4], input int ws[4][NO],
                           input int nb, output int e[NO]);
    for (int j = 0; j < NO; j++) begin
      e[j] = b[j];
      for (int k = 0; k < nb; k++) e[j] = e[j] + xs[k] * ws[k][j];
    end
  endtask

  // Index of first out[] lane differing from e, or -1
  function automatic int diff4(input int e[NO]);
    for (int j = 0; j < NO; j++) if (bus4.out[j] !== e[j]) return j;
    return -1;
  endfunction

  task automatic start4(input int b[NO]);
    for (int j = 0; j < NO; j++) bus4.bias[j] = b[j];
    bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
  endtask

  task automatic ack4();
    bus4.out_ready = 1'b1;
    tick();
    bus4.out_ready = 1'b0;
  endtask

  // One beat: wait (bounded) for in_ready, present data for one cycle, then idle gap
  task automatic beat4(input int x, input int w[NO], input int gap, input bit poke);
    int t = 0;
    while (bus4.in_ready !== 1'b1 && t < 50) begin
      tick();
      t++;
    end
    if (bus4.in_ready !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL beat_ready_timeout: in_ready=%b required 1", bus4.in_ready);
    end
    bus4.x_in     = x;
    for (int j = 0; j < NO; j++) bus4.w_in[j] = w[j];
    bus4.in_valid = 1'b1;
    if (poke) begin
      bus4.start = 1'b1;
      for (int j = 0; j < NO; j++) bus4.bias[j] = int'($urandom);
    end
    tick();
    bus4.in_valid = 1'b0;
    bus4.start    = 1'b0;
    bus4.x_in     = int'($urandom);
    for (int j = 0; j < NO; j++) bus4.w_in[j] = int'($urandom);
    repeat (gap) tick();
  endtask

  task automatic run_vec4(input int b[NO], input int xs[4], input int ws[4][NO],
                          input int gap, input bit b2b, input bit poke);
    if (b2b) begin
      for (int j = 0; j < NO; j++) bus4.bias[j] = b[j];
      bus4.out_ready = 1'b1;
      bus4.start     = 1'b1;
      tick();
      bus4.out_ready = 1'b0;
      bus4.start     = 1'b0;
    end else begin
      start4(b);
    end
    for (int k = 0; k < 4; k++) beat4(xs[k], ws[k], (k == 3) ? 0 : gap, poke && (k == 1));
  endtask

  task automatic rand_vec(output int b[NO], output int xs[4], output int ws[4][NO]);
    for (int j = 0; j < NO; j++) b[j] = int'($urandom);
    for (int k = 0; k < 4; k++) begin
      xs[k] = int'($urandom);
      for (int j = 0; j < NO; j++) ws[k][j] = int'($urandom);
    end
  endtask

  task automatic test_reset();
    bit zero4 = 1'b1;
    bit zero1 = 1'b1;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    for (int j = 0; j < NO; j++) begin
      if (bus4.out[j] !== 32'sd0) zero4 = 1'b0;
      if (bus1.out[j] !== 32'sd0) zero1 = 1'b0;
    end
    n_tests++;
    if (!zero4 || !zero1) begin
      n_fail++;
      $display("FAIL reset_out: out zero (N_IN=4,1)=%b%b required 11", zero4, zero1);
    end
    n_tests++;
    if ({bus4.out_valid, bus4.in_ready, bus4.busy, bus1.out_valid, bus1.in_ready, bus1.busy} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: valid/ready/busy=%b%b%b %b%b%b required 000 000",
               bus4.out_valid, bus4.in_ready, bus4.busy, bus1.out_valid, bus1.in_ready, bus1.busy);
    end
  endtask

  // T1 and T2: x=1..4, w[j]=100*j, with and without idle gaps between beats
  task automatic test_basic(input int gap);
    int b[NO];
    int w[NO];
    int e[NO];
    int d;
    for (int j = 0; j < NO; j++) begin
      b[j] = 0;
      w[j] = 100 * j;
    end
    start4(b);
    n_tests++;
    if (bus4.busy !== 1'b1 || bus4.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_g%0d_enter: busy/in_ready=%b%b required 11", gap, bus4.busy, bus4.in_ready);
    end
    beat4(1, w, gap, 1'b0);
    beat4(2, w, gap, 1'b0);
    for (int j = 0; j < NO; j++) e[j] = 300 * j;
    d = diff4(e);
    n_tests++;
    if (d >= 0) begin
      n_fail++;
      $display("FAIL basic_g%0d_partial: out[%0d]=%0d required %0d", gap, d, bus4.out[d], e[d]);
    end
    beat4(3, w, 0, 1'b0);
    n_tests++;
    if (bus4.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_g%0d_early_valid: out_valid=%b required 0", gap, bus4.out_valid);
    end
    beat4(4, w, 0, 1'b0);
    n_tests++;
    if (bus4.out_valid !== 1'b1 || bus4.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_g%0d_latency: out_valid/in_ready=%b%b required 10", gap, bus4.out_valid, bus4.in_ready);
    end
    for (int j = 0; j < NO; j++) e[j] = 1000 * j;
    d = diff4(e);
    n_tests++;
    if (d >= 0) begin
      n_fail++;
      $display("FAIL basic_g%0d_out: out[%0d]=%0d required %0d", gap, d, bus4.out[d], e[d]);
    end
    ack4();
    n_tests++;
    if (bus4.out_valid !== 1'b0 || bus4.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_g%0d_ack: out_valid/busy=%b%b required 00", gap, bus4.out_valid, bus4.busy);
    end
  endtask

  // T3: single-beat vector on the N_IN=1 instance
  task automatic test_single();
    bit ok = 1'b1;
    int bad = 0;
    for (int j = 0; j < NO; j++) begin
      bus1.bias[j] = -50;
      bus1.w_in[j] = 20;
    end
    bus1.start = 1'b1;
    tick();
    bus1.start    = 1'b0;
    bus1.x_in     = -3;
    bus1.in_valid = 1'b1;
    tick();
    bus1.in_valid = 1'b0;
    n_tests++;
    if (bus1.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL single_valid: out_valid=%b required 1", bus1.out_valid);
    end
    for (int j = 0; j < NO; j++) if (bus1.out[j] !== -32'sd110) begin
      ok  = 1'b0;
      bad = j;
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL single_out: out[%0d]=%0d required -110", bad, bus1.out[bad]);
    end
    bus1.out_ready = 1'b1;
    tick();
    bus1.out_ready = 1'b0;
  endtask

  // T4: 0x7FFFFFFF * 2 wraps to -2
  task automatic test_wrap();
    int b[NO];
    int xs[4];
    int ws[4][NO];
    int d;
    int e[NO];
    rand_vec(b, xs, ws);
    for (int j = 0; j < NO; j++) begin
      b[j]     = 0;
      ws[0][j] = 2;
    end
    xs[0] = 32'h7FFF_FFFF;
    xs[1] = 0;
    xs[2] = 0;
    xs[3] = 0;
    run_vec4(b, xs, ws, 0, 1'b0, 1'b0);
    for (int j = 0; j < NO; j++) e[j] = -2;
    d = diff4(e);
    n_tests++;
    if (d >= 0) begin
      n_fail++;
      $display("FAIL wrap_out: out[%0d]=%0d required -2", d, bus4.out[d]);
    end
    ack4();
  endtask

  // T5: consumer stalls with start pulsed, then takes result and starts the next vector
  task automatic test_hold();
    int b[NO];
    int xs[4];
    int ws[4][NO];
    int e[NO];
    int d;
    int b2[NO];
    rand_vec(b, xs, ws);
    run_vec4(b, xs, ws, 0, 1'b0, 1'b0);
    ref_model(b, xs, ws, 4, e);
    for (int c = 0; c < 5; c++) begin
      bus4.out_ready = 1'b0;
      bus4.start     = (c % 2 == 0);
      for (int j = 0; j < NO; j++) bus4.bias[j] = int'($urandom);
      tick();
      bus4.start = 1'b0;
      d = diff4(e);
      n_tests++;
      if (d >= 0 || bus4.out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_c%0d: out_valid=%b out[%0d]=%0d required valid=1 out=%0d",
                 c, bus4.out_valid, (d < 0) ? 0 : d, bus4.out[(d < 0) ? 0 : d], e[(d < 0) ? 0 : d]);
      end
    end
    rand_vec(b2, xs, ws);
    for (int j = 0; j < NO; j++) bus4.bias[j] = b2[j];
    bus4.out_ready = 1'b1;
    bus4.start     = 1'b1;
    tick();
    bus4.out_ready = 1'b0;
    bus4.start     = 1'b0;
    d = diff4(b2);
    n_tests++;
    if (d >= 0 || bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_b2b_load: in_ready/out_valid=%b%b out[%0d]=%0d required 10 bias=%0d",
               bus4.in_ready, bus4.out_valid, (d < 0) ? 0 : d, bus4.out[(d < 0) ? 0 : d], b2[(d < 0) ? 0 : d]);
    end
    for (int k = 0; k < 4; k++) beat4(xs[k], ws[k], 0, 1'b0);
    ref_model(b2, xs, ws, 4, e);
    d = diff4(e);
    n_tests++;
    if (d >= 0) begin
      n_fail++;
      $display("FAIL hold_b2b_out: out[%0d]=%0d required %0d", d, bus4.out[d], e[d]);
    end
    ack4();
  endtask

  // T6: reset in the middle of a vector, then a fresh vector
  task automatic test_reset_mid();
    int b[NO];
    int xs[4];
    int ws[4][NO];
    int e[NO];
    int d;
    rand_vec(b, xs, ws);
    start4(b);
    beat4(xs[0], ws[0], 0, 1'b0);
    beat4(xs[1], ws[1], 0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int j = 0; j < NO; j++) e[j] = 0;
    d = diff4(e);
    n_tests++;
    if (d >= 0 || bus4.in_ready !== 1'b0 || bus4.busy !== 1'b0 || bus4.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_state: in_ready/busy/out_valid=%b%b%b out[%0d]=%0d required 000 out=0",
               bus4.in_ready, bus4.busy, bus4.out_valid, (d < 0) ? 0 : d, bus4.out[(d < 0) ? 0 : d]);
    end
    rand_vec(b, xs, ws);
    run_vec4(b, xs, ws, 1, 1'b0, 1'b0);
    ref_model(b, xs, ws, 4, e);
    d = diff4(e);
    n_tests++;
    if (d >= 0) begin
      n_fail++;
      $display("FAIL midrst_fresh: out[%0d]=%0d required %0d", d, bus4.out[d], e[d]);
    end
    ack4();
  endtask

  // Random vectors, random gaps/stalls, start poked mid-vector, chained starts
  task automatic test_back_to_back();
    int b[NO];
    int xs[4];
    int ws[4][NO];
    int e[NO];
    int d;
    bit pending = 1'b0;
    for (int it = 0; it < 10; it++) begin
      rand_vec(b, xs, ws);
      run_vec4(b, xs, ws, $urandom_range(0, 2), pending, ($urandom_range(0, 1) == 1));
      ref_model(b, xs, ws, 4, e);
      repeat ($urandom_range(0, 3)) tick();
      d = diff4(e);
      n_tests++;
      if (d >= 0 || bus4.out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL rand_it%0d: out_valid=%b out[%0d]=%0d required valid=1 out=%0d",
                 it, bus4.out_valid, (d < 0) ? 0 : d, bus4.out[(d < 0) ? 0 : d], e[(d < 0) ? 0 : d]);
      end
      pending = ($urandom_range(0, 1) == 1);
      if (!pending) ack4();
    end
    if (pending) ack4();
  endtask

  initial begin
    rst             = 1'b1;
    bus4.start      = 1'b0;
    bus4.in_valid   = 1'b0;
    bus4.out_ready  = 1'b0;
    bus4.x_in       = 0;
    bus1.start      = 1'b0;
    bus1.in_valid   = 1'b0;
    bus1.out_ready  = 1'b0;
    bus1.x_in       = 0;
    for (int j = 0; j < NO; j++) begin
      bus4.bias[j] = 0;
      bus4.w_in[j] = 0;
      bus1.bias[j] = 0;
      bus1.w_in[j] = 0;
    end
    test_reset();
    test_basic(0);
    test_basic(3);
    test_single();
    test_wrap();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
